// File: rtl/sudoku_pkg.sv
// Shared sudoku types: cell/grid payloads, key command codes and grid geometry.
package sudoku_pkg;

  localparam int unsigned GRID_N = 9;
  localparam int unsigned CELL_W = 4;
  localparam int unsigned IDX_W  = 4;
  localparam int unsigned KEY_W  = 4;

  typedef logic [CELL_W-1:0]              cell_t;
  typedef cell_t [GRID_N-1:0][GRID_N-1:0] grid_t;
  typedef logic [IDX_W-1:0]               idx_t;
  typedef logic [KEY_W-1:0]               key_t;

  localparam key_t KEY_NONE      = 4'd0;
  localparam key_t KEY_UP        = 4'd1;
  localparam key_t KEY_DOWN      = 4'd2;
  localparam key_t KEY_LEFT      = 4'd3;
  localparam key_t KEY_RIGHT     = 4'd4;
  localparam key_t KEY_WRITE     = 4'd5;
  localparam key_t KEY_CLEAR     = 4'd6;
  localparam key_t KEY_CLEAR_ALL = 4'd7;

  localparam cell_t MAX_DIGIT = 4'd9;
  localparam idx_t  IDX_LAST  = IDX_W'(GRID_N - 1);

  // A nonzero given always wins over whatever the player typed.
  function automatic cell_t merge_cell(input cell_t given, input cell_t edit);
    return (given != '0) ? given : edit;
  endfunction

endpackage

// File: rtl/gamelogic_cursor.sv
// Board cursor: moves on arrow keys and wraps modulo GRID_N on both axes.
import sudoku_pkg::*;

module gamelogic_cursor (
  input  logic clock,
  input  logic reset_n,
  input  logic cmd_valid,
  input  key_t key,
  output idx_t row,
  output idx_t col
);

  idx_t row_n;
  idx_t col_n;

  function automatic idx_t wrap_dec(input idx_t v);
    return (v == '0) ? IDX_LAST : v - idx_t'(1);
  endfunction

  function automatic idx_t wrap_inc(input idx_t v);
    return (v == IDX_LAST) ? '0 : v + idx_t'(1);
  endfunction

  always_comb begin
    row_n = row;
    col_n = col;
    if (cmd_valid) begin
      case (key)
        KEY_UP:    row_n = wrap_dec(row);
        KEY_DOWN:  row_n = wrap_inc(row);
        KEY_LEFT:  col_n = wrap_dec(col);
        KEY_RIGHT: col_n = wrap_inc(col);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      row <= '0;
      col <= '0;
    end else begin
      row <= row_n;
      col <= col_n;
    end
  end

endmodule

// File: rtl/gamelogic_top.sv
// Sudoku board logic: edit grid updated by key commands or guess loads, merged
// with the puzzle givens for display.
import sudoku_pkg::*;

module gamelogic_top (
  input  logic  clock,
  input  logic  reset_n,
  input  logic  board_enable,
  input  logic  board_sel,
  input  key_t  key_input,
  input  cell_t user_value,
  input  grid_t initial_grid,
  input  grid_t guess_grid,
  output grid_t display_grid
);

  grid_t edit_grid;
  grid_t edit_grid_n;
  idx_t  cur_row;
  idx_t  cur_col;
  logic  play_valid_c;
  logic  load_valid_c;
  logic  cell_free_c;

  assign play_valid_c = board_enable && board_sel;
  assign load_valid_c = board_enable && !board_sel;
  assign cell_free_c  = (initial_grid[cur_row][cur_col] == '0);

  gamelogic_cursor u_cursor (
    .clock     (clock),
    .reset_n   (reset_n),
    .cmd_valid (play_valid_c),
    .key       (key_input),
    .row       (cur_row),
    .col       (cur_col)
  );

  // Edits act on the cursor position sampled in the same cycle as the command.
  always_comb begin
    edit_grid_n = edit_grid;
    if (load_valid_c) begin
      edit_grid_n = guess_grid;
    end else if (play_valid_c) begin
      case (key_input)
        KEY_WRITE: begin
          if (cell_free_c && (user_value <= MAX_DIGIT)) begin
            edit_grid_n[cur_row][cur_col] = user_value;
          end
        end
        KEY_CLEAR: begin
          if (cell_free_c) begin
            edit_grid_n[cur_row][cur_col] = '0;
          end
        end
        KEY_CLEAR_ALL: edit_grid_n = '0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      edit_grid <= '0;
    end else begin
      edit_grid <= edit_grid_n;
    end
  end

  always_comb begin
    display_grid = '0;
    for (int r = 0; r < int'(GRID_N); r++) begin
      for (int c = 0; c < int'(GRID_N); c++) begin
        display_grid[r][c] = merge_cell(initial_grid[r][c], edit_grid[r][c]);
      end
    end
  end

endmodule

// File: tb/tb_gamelogic_top.sv
// Directed plus randomized checks of gamelogic_top against a cell-array board model.
import sudoku_pkg::*;

module tb_gamelogic_top;

  logic  clock = 1'b0;
  logic  reset_n;
  logic  board_enable;
  logic  board_sel;
  key_t  key_input;
  cell_t user_value;
  grid_t initial_grid;
  grid_t guess_grid;
  grid_t display_grid;

  int vectors = 0;
  int miscompares = 0;

  // Reference board: plain 2-D array and integer cursor.
  int m_edit [9][9];
  int m_row;
  int m_col;

  gamelogic_top dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .board_enable (board_enable),
    .board_sel    (board_sel),
    .key_input    (key_input),
    .user_value   (user_value),
    .initial_grid (initial_grid),
    .guess_grid   (guess_grid),
    .display_grid (display_grid)
  );

  always #5 clock = ~clock;

  function automatic int given(input int r, input int c);
    return int'(initial_grid[r][c]);
  endfunction

  task automatic model_edge();
    int k;
    int v;
    k = int'(key_input);
    v = int'(user_value);
    if (!reset_n) begin
      foreach (m_edit[r, c]) m_edit[r][c] = 0;
      m_row = 0;
      m_col = 0;
    end else if (board_enable && !board_sel) begin
      foreach (m_edit[r, c]) m_edit[r][c] = int'(guess_grid[r][c]);
    end else if (board_enable) begin
      case (k)
        1: m_row = (m_row + 8) % 9;
        2: m_row = (m_row + 1) % 9;
        3: m_col = (m_col + 8) % 9;
        4: m_col = (m_col + 1) % 9;
        5: if (given(m_row, m_col) == 0 && v <= 9) m_edit[m_row][m_col] = v;
        6: if (given(m_row, m_col) == 0) m_edit[m_row][m_col] = 0;
        7: foreach (m_edit[r, c]) m_edit[r][c] = 0;
        default: ;
      endcase
    end
  endtask

  function automatic grid_t model_display();
    grid_t g;
    for (int r = 0; r < 9; r++)
      for (int c = 0; c < 9; c++)
        g[r][c] = (given(r, c) != 0) ? initial_grid[r][c] : cell_t'(m_edit[r][c]);
    return g;
  endfunction

  task automatic check_grid(input string tag);
    grid_t exp;
    exp = model_display();
    vectors++;
    assert (display_grid === exp) else begin
      miscompares++;
      $error("FAIL %s: display_grid got %h expected %h", tag, display_grid, exp);
    end
  endtask

  task automatic check_cell(input string tag, input int r, input int c, input int exp);
    vectors++;
    assert (display_grid[r][c] === cell_t'(exp)) else begin
      miscompares++;
      $error("FAIL %s: cell[%0d][%0d] got %0d expected %0d", tag, r, c, display_grid[r][c], exp);
    end
  endtask

  // One clock edge: model follows the same sampled inputs, then outputs are checked.
  task automatic step(input string tag);
    @(posedge clock);
    model_edge();
    #1;
    check_grid(tag);
  endtask

  task automatic play(input int k, input int v, input string tag);
    board_enable = 1'b1;
    board_sel    = 1'b1;
    key_input    = key_t'(k);
    user_value   = cell_t'(v);
    step(tag);
    key_input    = KEY_NONE;
  endtask

  initial begin
    reset_n      = 1'b0;
    board_enable = 1'b0;
    board_sel    = 1'b1;
    key_input    = KEY_NONE;
    user_value   = '0;
    initial_grid = '0;
    guess_grid   = '0;
    initial_grid[0][0] = 4'd5;
    m_row = 0;
    m_col = 0;
    foreach (m_edit[r, c]) m_edit[r][c] = 0;

    step("reset");
    reset_n = 1'b1;
    check_cell("reset_given", 0, 0, 5);
    check_cell("reset_empty", 4, 7, 0);

    play(4, 0, "right");
    play(5, 7, "write7");
    check_cell("write7", 0, 1, 7);

    play(3, 0, "left");
    play(5, 3, "protect_write");
    check_cell("protect_write", 0, 0, 5);
    play(6, 0, "protect_clear");
    check_cell("protect_clear", 0, 0, 5);

    play(1, 0, "up_wrap");
    play(3, 0, "left_wrap");
    play(5, 9, "write9");
    check_cell("wrap_write9", 8, 8, 9);

    guess_grid[4][4] = 4'd2;
    board_enable = 1'b1;
    board_sel    = 1'b0;
    key_input    = KEY_WRITE;
    user_value   = 4'd1;
    step("load");
    check_cell("load", 4, 4, 2);
    check_cell("load_overwrites", 8, 8, 0);
    play(7, 0, "clear_all");
    check_cell("clear_all", 4, 4, 0);

    board_enable = 1'b0;
    board_sel    = 1'b1;
    key_input    = KEY_WRITE;
    user_value   = 4'd4;
    step("disabled");
    check_cell("disabled", 8, 8, 0);
    play(5, 12, "write12");
    check_cell("write12", 8, 8, 0);

    play(5, 6, "write6");
    check_cell("write6", 8, 8, 6);
    reset_n = 1'b0;
    play(5, 3, "reset_mid");
    reset_n = 1'b1;
    check_cell("reset_mid", 8, 8, 0);
    play(5, 8, "after_reset");
    check_cell("after_reset_cursor", 0, 0, 5);

    // Randomized phase; givens reshuffled periodically.
    for (int i = 0; i < 600; i++) begin
      if (i % 150 == 0) begin
        for (int r = 0; r < 9; r++)
          for (int c = 0; c < 9; c++)
            initial_grid[r][c] = ($urandom_range(0, 3) == 0) ? cell_t'($urandom_range(1, 9)) : '0;
      end
      for (int r = 0; r < 9; r++)
        for (int c = 0; c < 9; c++)
          guess_grid[r][c] = ($urandom_range(0, 1) == 0) ? cell_t'($urandom_range(0, 9)) : '0;
      reset_n      = ($urandom_range(0, 79) != 0);
      board_enable = ($urandom_range(0, 7) != 0);
      board_sel    = ($urandom_range(0, 24) != 0);
      key_input    = ($urandom_range(0, 3) == 0) ? key_t'($urandom_range(0, 15))
                                                 : key_t'($urandom_range(0, 6));
      user_value   = cell_t'($urandom_range(0, 15));
      step("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/gamelogic_top.md
GAMELOGIC_TOP -- requirements
Module: gamelogic_top

Interface
REQ-001 SHALL have port: clock  in  1  single rising-edge clock for all state.
REQ-002 SHALL have port: reset_n  in  1  synchronous, active-low reset, sampled on rising clock.
REQ-003 SHALL have port: board_enable  in  1  qualifies key_input and board_sel for the current cycle.
REQ-004 SHALL have port: board_sel  in  1  1 = play (execute key command), 0 = load guess grid.
REQ-005 SHALL have port: key_input  in  4  key command code, one command per enabled cycle.
REQ-006 SHALL have port: user_value  in  4  value to write on a write command, valid range 0..9.
REQ-007 SHALL have port: initial_grid  in  9x9x4  puzzle givens [row][col]; 0 = empty cell, 1..9 = fixed digit.
REQ-008 SHALL have port: guess_grid  in  9x9x4  saved guesses [row][col], loaded into the edit grid on a load cycle.
REQ-009 SHALL have port: display_grid  out  9x9x4  merged board shown to the player [row][col].

Function
REQ-010 SHALL hold an internal 9x9x4 edit grid and a cursor (row 0..8, col 0..8), both registered on clock.
REQ-011 SHALL, in a cycle with board_enable=1 and board_sel=0, copy every guess_grid cell into the edit grid at the next edge; cursor unchanged; key_input ignored.
REQ-012 SHALL, in a cycle with board_enable=1 and board_sel=1, execute key_input at that edge; each cycle the code is present counts as one command.
REQ-013 SHALL use key codes: 0 none; 1 up (row-1); 2 down (row+1); 3 left (col-1); 4 right (col+1); 5 write; 6 clear cell; 7 clear all guesses; 8..15 ignored.
REQ-014 SHALL wrap the cursor modulo 9: up at row 0 -> row 8; down at row 8 -> row 0; left at col 0 -> col 8; right at col 8 -> col 0.
REQ-015 SHALL, on write (5), store user_value into the edit cell at the cursor when user_value <= 9; writing 0 clears the cell; user_value 10..15 leaves the edit grid unchanged.
REQ-016 SHALL ignore write and clear-cell commands when initial_grid at the cursor is nonzero (given cell is protected).
REQ-017 SHALL, on clear cell (6), set the edit cell at the cursor to 0; on clear all (7), set all 81 edit cells to 0; the cursor is unchanged in both cases.
REQ-018 SHALL drive display_grid combinationally per cell: initial_grid[r][c] if it is nonzero, else the edit cell [r][c].
REQ-019 SHALL, with board_enable=0, leave the edit grid and cursor unchanged; display_grid still follows REQ-018.
REQ-020 SHALL make an edit visible on display_grid immediately after the clock edge that executes it (latency 1 edge from command sample).
REQ-021 SHALL have no output handshake; each command is single-cycle and non-blocking.

Reset
REQ-022 SHALL, when reset_n=0 at a rising edge, clear all edit cells to 0 and set the cursor to (0,0); reset has priority over every command.
REQ-023 SHALL make display_grid equal initial_grid after reset.
REQ-024 SHALL apply reset normally when it is asserted mid-sequence, discarding any command sampled in the same cycle.

Structure
REQ-025 SHALL take from shared package sudoku_pkg: cell_t (4-bit), grid_t (9x9 cell_t), the key-code constants, and GRID_N=9.
REQ-026 SHALL place cursor movement and wrap logic in one sub-module, gamelogic_cursor; the edit grid and display merge SHALL stay in the top module.

Verification
REQ-027 SHALL verify reset: assert reset_n=0 for one edge, initial_grid[0][0]=5, all other cells 0 -> display_grid[0][0]=5, all other display cells 0.
REQ-028 SHALL verify write: after reset, key 4 (right) then key 5 with user_value=7 -> display_grid[0][1]=7.
REQ-029 SHALL verify given protection: initial_grid[0][0]=5, cursor (0,0), key 5 with user_value=3 -> display_grid[0][0] stays 5; key 6 -> still 5.
REQ-030 SHALL verify wrap: from (0,0), key 1 (up) then key 3 (left), then write 9 -> display_grid[8][8]=9.
REQ-031 SHALL verify load and clear: board_sel=0 with guess_grid[4][4]=2 -> display_grid[4][4]=2; then key 7 -> display_grid[4][4]=0.
REQ-032 SHALL verify ignored input: board_enable=0 with key 5 and user_value=4 -> no change; enabled write with user_value=12 -> no change.
